// File: rtl/binary_arith_pkg.sv
// Shared constants, state encoding and sizing helpers for the serial
// binary arithmetic blocks.
package binary_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SUB  = ST_SUB,
    S_DONE = ST_DONE
  } state_e;

  // Bit counter must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage : binary_arith_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_bit

// File: rtl/binary_subtractor_serial.sv
// Bit-serial subtractor recovering a = sum - b, LSB first, one bit per clock,
// with start/busy/done handshake and borrow/overflow flags.
module binary_subtractor_serial
  import binary_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic [WIDTH:0]     sub_q, sub_d;
  logic [WIDTH:0]     res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               borrow_q, borrow_d;
  logic               overflow_q, overflow_d;

  logic               d_bit_c;
  logic               bout_c;
  logic [WIDTH:0]     diff_c;

  full_subtractor_bit u_fs (
    .x    (sum_q[0]),
    .y    (sub_q[0]),
    .bin  (brw_q),
    .d    (d_bit_c),
    .bout (bout_c)
  );

  // Difference bits enter at the MSB so the final result lands LSB-aligned.
  assign diff_c = {d_bit_c, res_q[WIDTH:1]};

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    sub_d      = sub_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    brw_d      = brw_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    a_d        = a_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_SUB;
          sum_d   = sum;
          sub_d   = {1'b0, b};
          res_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SUB: begin
        res_d = diff_c;
        brw_d = bout_c;
        cnt_d = cnt_q + CNT_W'(1);
        sum_d = {1'b0, sum_q[WIDTH:1]};
        sub_d = {1'b0, sub_q[WIDTH:1]};
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          a_d        = diff_c[WIDTH-1:0];
          borrow_d   = bout_c;
          overflow_d = diff_c[WIDTH] & ~bout_c;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      sub_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      brw_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_q        <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      sub_q      <= sub_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      brw_q      <= brw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a_q        <= a_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign a        = a_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule : binary_subtractor_serial
